// File: rtl/fcl_pkg.sv
// Shared definitions for the fully-connected tile-streaming layer engine.
//   fcl_state_e : layer sequencer states
//   ACT_*       : activation select encodings carried on act_mode
//   fcl_cw      : index width helper that never returns zero
package fcl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STREAM = 3'd2,
    ST_BIAS   = 3'd3,
    ST_ACT    = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_DONE   = 3'd6
  } fcl_state_e;

  localparam logic [1:0] ACT_NONE  = 2'd0;
  localparam logic [1:0] ACT_RELU  = 2'd1;
  localparam logic [1:0] ACT_RELU6 = 2'd2;

  // Width needed to index n items; a single item still gets one bit.
  function automatic int fcl_cw(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/fcl_act_sat.sv
// Saturate a wide signed accumulator to DW bits, then apply the activation.
//   acc  : accumulator value (AW bits, signed, Q.FRAC)
//   mode : activation select (ACT_NONE / ACT_RELU / ACT_RELU6, 3 behaves as none)
//   y    : activated result (DW bits, signed, Q.FRAC)
module fcl_act_sat
  import fcl_pkg::*;
#(
  parameter int DW   = 16,
  parameter int FRAC = 8,
  parameter int AW   = 38
) (
  input  logic signed [AW-1:0] acc,
  input  logic        [1:0]    mode,
  output logic signed [DW-1:0] y
);

  localparam logic signed [AW-1:0] SAT_MAX   = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN   = ~SAT_MAX;
  localparam logic signed [DW-1:0] RELU6_MAX = DW'(6 << FRAC);

  logic signed [DW-1:0] sat_s;

  // Clamp to the representable DW range, then shape by activation mode.
  always_comb begin
    sat_s = '0;
    y     = '0;
    if (acc > SAT_MAX) begin
      sat_s = SAT_MAX[DW-1:0];
    end else if (acc < SAT_MIN) begin
      sat_s = SAT_MIN[DW-1:0];
    end else begin
      sat_s = acc[DW-1:0];
    end
    case (mode)
      ACT_RELU: begin
        if (sat_s < 0) begin
          y = '0;
        end else begin
          y = sat_s;
        end
      end
      ACT_RELU6: begin
        if (sat_s < 0) begin
          y = '0;
        end else if (sat_s > RELU6_MAX) begin
          y = RELU6_MAX;
        end else begin
          y = sat_s;
        end
      end
      default: y = sat_s;
    endcase
  end

endmodule

// File: rtl/fcl_tile_stream.sv
// Fully-connected layer engine: weights arrive as TILE-lane beats ordered by
// output tile, input tile, then row; each output tile is accumulated, biased,
// activated and drained one neuron at a time.
//   clk, rst          : clock, asynchronous active-high reset
//   start, act_mode   : layer start (accepted only when idle), activation select
//   inputs, biases    : activations and biases, latched at start
//   w_valid/w_ready/w_data : weight beat handshake
//   o_valid/o_ready/o_data/o_idx : result handshake with neuron index
//   busy, done        : layer in progress, one-cycle completion pulse
module fcl_tile_stream
  import fcl_pkg::*;
#(
  parameter int IN_N  = 60,
  parameter int OUT_N = 50,
  parameter int TILE  = 20,
  parameter int DW    = 16,
  parameter int FRAC  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             act_mode,
  input  logic [IN_N*DW-1:0]     inputs,
  input  logic [OUT_N*DW-1:0]    biases,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic [TILE*DW-1:0]     w_data,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [DW-1:0]          o_data,
  output logic [fcl_cw(OUT_N)-1:0] o_idx,
  output logic                   busy,
  output logic                   done
);

  localparam int NOB = (OUT_N + TILE - 1) / TILE;
  localparam int NIB = (IN_N + TILE - 1) / TILE;
  localparam int AW  = 2 * DW + $clog2(IN_N);
  localparam int IW  = fcl_cw(OUT_N);
  localparam int RW  = fcl_cw(TILE);
  localparam int OBW = fcl_cw(NOB);
  localparam int IBW = fcl_cw(NIB);
  localparam int INW = NIB * TILE * DW;
  localparam int BSW = NOB * TILE * DW;

  fcl_state_e            state_r;
  logic [1:0]            mode_r;
  logic [INW-1:0]        in_r;
  logic [BSW-1:0]        bias_r;
  logic signed [AW-1:0]  acc_r [TILE];
  logic [TILE*DW-1:0]    res_r;
  logic [OBW-1:0]        ob_r;
  logic [IBW-1:0]        ib_r;
  logic [RW-1:0]         r_r;

  logic [INW-1:0]        in_sh_s;
  logic [BSW-1:0]        bias_sh_s;
  logic [TILE*DW-1:0]    res_sh_s;
  logic [TILE*DW-1:0]    act_s;
  logic signed [2*DW-1:0] prod_s;
  logic signed [AW-1:0]  beat_sum_s;
  int                    row_base_s;
  int                    next_r_s;
  logic                  next_row_ok_s;

  // Inputs and biases are zero-padded to whole tiles; shifting brings the
  // current tile down to the low lanes.
  assign in_sh_s   = in_r >> (int'(ib_r) * TILE * DW);
  assign bias_sh_s = bias_r >> (int'(ob_r) * TILE * DW);
  assign res_sh_s  = res_r >> (next_r_s * DW);

  // Row bookkeeping for the drain phase.
  always_comb begin
    row_base_s    = int'(ob_r) * TILE;
    next_r_s      = int'(r_r) + 1;
    next_row_ok_s = (next_r_s < TILE) && (row_base_s + next_r_s < OUT_N);
  end

  // Dot product of one weight beat with the current input tile; each product
  // is rescaled on its own and lanes past the last input are masked.
  always_comb begin
    beat_sum_s = '0;
    prod_s     = '0;
    for (int i = 0; i < TILE; i++) begin
      prod_s = $signed(in_sh_s[i*DW +: DW]) * $signed(w_data[i*DW +: DW]);
      if (int'(ib_r) * TILE + i < IN_N) begin
        beat_sum_s = beat_sum_s + AW'(prod_s >>> FRAC);
      end else begin
        beat_sum_s = beat_sum_s;
      end
    end
  end

  genvar k;
  generate
    for (k = 0; k < TILE; k++) begin : g_act
      fcl_act_sat #(.DW(DW), .FRAC(FRAC), .AW(AW)) u_act (
        .acc  (acc_r[k]),
        .mode (mode_r),
        .y    (act_s[k*DW +: DW])
      );
    end
  endgenerate

  // Layer sequencer with registered handshake and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      mode_r  <= ACT_NONE;
      in_r    <= '0;
      bias_r  <= '0;
      res_r   <= '0;
      ob_r    <= '0;
      ib_r    <= '0;
      r_r     <= '0;
      w_ready <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_idx   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int j = 0; j < TILE; j++) acc_r[j] <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            in_r    <= INW'(inputs);
            bias_r  <= BSW'(biases);
            mode_r  <= act_mode;
            busy    <= 1'b1;
            state_r <= ST_LOAD;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_LOAD: begin
          for (int j = 0; j < TILE; j++) acc_r[j] <= '0;
          ob_r    <= '0;
          ib_r    <= '0;
          r_r     <= '0;
          w_ready <= 1'b1;
          state_r <= ST_STREAM;
        end
        ST_STREAM: begin
          if (w_valid && w_ready) begin
            for (int j = 0; j < TILE; j++) begin
              if (r_r == RW'(j)) acc_r[j] <= acc_r[j] + beat_sum_s;
            end
            if (r_r == RW'(TILE - 1)) begin
              r_r <= '0;
              if (ib_r == IBW'(NIB - 1)) begin
                ib_r    <= '0;
                w_ready <= 1'b0;
                state_r <= ST_BIAS;
              end else begin
                ib_r <= ib_r + IBW'(1);
              end
            end else begin
              r_r <= r_r + RW'(1);
            end
          end
        end
        ST_BIAS: begin
          for (int j = 0; j < TILE; j++) begin
            acc_r[j] <= acc_r[j] + AW'($signed(bias_sh_s[j*DW +: DW]));
          end
          state_r <= ST_ACT;
        end
        ST_ACT: begin
          // Activated results are kept so the accumulators can be reused.
          res_r   <= act_s;
          for (int j = 0; j < TILE; j++) acc_r[j] <= '0;
          r_r     <= '0;
          o_valid <= 1'b1;
          o_data  <= act_s[DW-1:0];
          o_idx   <= IW'(row_base_s);
          state_r <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (o_valid && o_ready) begin
            if (next_row_ok_s) begin
              r_r    <= r_r + RW'(1);
              o_data <= res_sh_s[DW-1:0];
              o_idx  <= IW'(row_base_s + next_r_s);
            end else begin
              o_valid <= 1'b0;
              r_r     <= '0;
              if (ob_r == OBW'(NOB - 1)) begin
                ob_r    <= '0;
                done    <= 1'b1;
                state_r <= ST_DONE;
              end else begin
                ob_r    <= ob_r + OBW'(1);
                w_ready <= 1'b1;
                state_r <= ST_STREAM;
              end
            end
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          w_ready <= 1'b0;
          o_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fcl_tile_stream.sv
// Scoreboard bench for fcl_tile_stream: a reference model computes each
// neuron from the weight matrix with plain arithmetic; a monitor pops and
// compares results as the DUT emits them.
module tb_fcl_tile_stream;

  localparam int IN_N  = 3;
  localparam int OUT_N = 3;
  localparam int TILE  = 2;
  localparam int DW    = 16;
  localparam int FRAC  = 8;
  localparam int NOB   = (OUT_N + TILE - 1) / TILE;
  localparam int NIB   = (IN_N + TILE - 1) / TILE;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic [1:0]             act_mode = 2'd0;
  logic [IN_N*DW-1:0]     inputs = '0;
  logic [OUT_N*DW-1:0]    biases = '0;
  logic                   w_valid = 1'b0;
  logic                   w_ready;
  logic [TILE*DW-1:0]     w_data = '0;
  logic                   o_valid;
  logic                   o_ready = 1'b1;
  logic [DW-1:0]          o_data;
  logic [1:0]             o_idx;
  logic                   busy;
  logic                   done;

  fcl_tile_stream #(.IN_N(IN_N), .OUT_N(OUT_N), .TILE(TILE), .DW(DW), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .start(start), .act_mode(act_mode),
    .inputs(inputs), .biases(biases),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_idx(o_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; logic [15:0] data; } exp_t;
  exp_t        exp_q[$];
  int          xv[IN_N];
  int          bv[OUT_N];
  int          wv[OUT_N][IN_N];
  logic [15:0] got[OUT_N];
  logic [15:0] ref0[OUT_N];
  int          checks = 0;
  int          failures = 0;
  int          dones_seen = 0;
  int          dones_exp = 0;
  bit          stall_en = 1'b0;
  bit          pend = 1'b0;
  logic [15:0] pdata;
  logic [1:0]  pidx;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference neuron: sum of rescaled products plus bias, saturated, activated.
  function automatic logic [15:0] ref_out(input int o, input int mode);
    longint a = 0;
    for (int j = 0; j < IN_N; j++) a += (longint'(xv[j]) * longint'(wv[o][j])) >>> FRAC;
    a += bv[o];
    if (a > 32767) a = 32767;
    if (a < -32768) a = -32768;
    if (mode == 1 && a < 0) a = 0;
    if (mode == 2) begin
      if (a < 0) a = 0;
      if (a > (6 <<< FRAC)) a = 6 <<< FRAC;
    end
    return a[15:0];
  endfunction

  // Consumer readiness, changed just after each rising edge.
  always begin
    @(posedge clk);
    #1;
    o_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Output monitor: hold-stability, scoreboard compare, done accounting.
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("hold_valid", o_valid, 1);
        chk("hold_idx", o_idx, pidx);
        chk("hold_data", o_data, pdata);
      end
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output idx=%0d data=0x%0h required=none", o_idx, o_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("o_idx", o_idx, e.idx);
          chk("o_data", o_data, e.data);
          if (int'(o_idx) < OUT_N) got[o_idx] = o_data;
        end
      end
      pend  = o_valid && !o_ready;
      pidx  = o_idx;
      pdata = o_data;
      if (done) begin
        dones_seen++;
        chk("queue_empty_at_done", exp_q.size(), 0);
      end
    end
  end

  task automatic apply_pins();
    for (int j = 0; j < IN_N; j++) inputs[j*DW +: DW] = xv[j][DW-1:0];
    for (int o = 0; o < OUT_N; o++) biases[o*DW +: DW] = bv[o][DW-1:0];
  endtask

  task automatic fill_const(input int x, input int w, input int b);
    for (int j = 0; j < IN_N; j++) xv[j] = x;
    for (int o = 0; o < OUT_N; o++) begin
      bv[o] = b;
      for (int j = 0; j < IN_N; j++) wv[o][j] = w;
    end
  endtask

  task automatic fill_rand(input bit wide);
    for (int j = 0; j < IN_N; j++) xv[j] = int'($urandom_range(0, 2047)) - 1024;
    for (int o = 0; o < OUT_N; o++) begin
      bv[o] = int'($urandom_range(0, 4095)) - 2048;
      for (int j = 0; j < IN_N; j++)
        wv[o][j] = wide ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 2047)) - 1024;
    end
  endtask

  // Present one beat; entered and left just after a rising edge.
  task automatic send_beat(input logic [TILE*DW-1:0] d, input bit gaps);
    int  n = 0;
    bit  rdy = 1'b0;
    if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    w_valid = 1'b1;
    w_data  = d;
    while (!rdy && n < 200) begin
      @(negedge clk);
      rdy = w_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!rdy) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout actual=no_ready required=ready");
    end
    w_valid = 1'b0;
    w_data  = {TILE{16'hA5A5}};
  endtask

  // Beats follow tile/row order; padded lanes carry junk that must be masked.
  task automatic send_beats(input bit gaps, input int limit);
    int sent = 0;
    for (int ob = 0; ob < NOB; ob++)
      for (int ib = 0; ib < NIB; ib++)
        for (int r = 0; r < TILE; r++) begin
          logic [TILE*DW-1:0] beat;
          for (int i = 0; i < TILE; i++) begin
            int row = ob * TILE + r;
            int col = ib * TILE + i;
            int v;
            v = (row < OUT_N && col < IN_N) ? wv[row][col] : int'($urandom_range(0, 65535));
            beat[i*DW +: DW] = v[DW-1:0];
          end
          if (sent < limit) send_beat(beat, gaps);
          sent++;
        end
  endtask

  task automatic poke_drain();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_valid && n < 3000);
    chk("poke_saw_drain", o_valid, 1);
    if (o_valid) begin
      start    = 1'b1;
      act_mode = 2'd1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic run_layer(input int mode, input bit gaps, input bit stall, input bit poke);
    int n = 0;
    for (int o = 0; o < OUT_N; o++) begin
      exp_t e;
      e.idx  = o;
      e.data = ref_out(o, mode);
      exp_q.push_back(e);
      got[o] = 16'hBAD0;
    end
    dones_exp++;
    stall_en = stall;
    apply_pins();
    act_mode = mode[1:0];
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    fork
      send_beats(gaps, NOB * NIB * TILE);
      begin if (poke) poke_drain(); end
    join
    while (dones_seen < dones_exp && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("done_count", dones_seen, dones_exp);
    @(posedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);
    stall_en = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_o_data", o_data, 0);
    chk("rst_o_idx", o_idx, 0);
    @(posedge clk); #1;

    // 1.0 * 1.0 over three inputs gives 3.0 on every neuron.
    fill_const(32'sh100, 32'sh100, 0);
    run_layer(0, 1'b0, 1'b0, 1'b0);
    for (int o = 0; o < OUT_N; o++) chk("ones_layer", got[o], 16'h0300);

    // Accumulate 10.0 under ReLU6, then -2.0 under ReLU and no activation.
    fill_const(32'sh100, 32'sh100, 0);
    xv[0] = 32'sh500; xv[1] = 32'sh500; xv[2] = 0;
    run_layer(2, 1'b0, 1'b0, 1'b0);
    chk("relu6_clamp", got[0], 16'h0600);
    xv[0] = -32'sh100; xv[1] = -32'sh100;
    run_layer(1, 1'b0, 1'b0, 1'b0);
    chk("relu_neg", got[1], 16'h0000);
    run_layer(0, 1'b0, 1'b0, 1'b0);
    chk("none_neg", got[2], 16'hFE00);

    // 127.0 * 127.0 summed well beyond range saturates positive.
    fill_const(32'sh7F00, 32'sh7F00, 0);
    run_layer(0, 1'b1, 1'b0, 1'b0);
    chk("overflow_sat", got[0], 16'h7FFF);

    // Same layer with and without handshake stalls must match.
    fill_rand(1'b0);
    run_layer(0, 1'b0, 1'b0, 1'b0);
    for (int o = 0; o < OUT_N; o++) ref0[o] = got[o];
    run_layer(0, 1'b1, 1'b1, 1'b0);
    for (int o = 0; o < OUT_N; o++) chk("stall_equal", got[o], ref0[o]);

    for (int t = 0; t < 8; t++) begin
      fill_rand(t[0]);
      run_layer(int'($urandom_range(0, 3)), t[1], t[2], 1'b0);
    end

    // Abort mid-stream; nothing may be emitted and no done may follow.
    fill_rand(1'b0);
    apply_pins();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_beats(1'b0, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_w_ready", w_ready, 0);
    chk("abort_o_valid", o_valid, 0);
    chk("abort_done", done, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    fill_rand(1'b0);
    run_layer(1, 1'b1, 1'b1, 1'b0);

    // A start during drain must be ignored.
    fill_rand(1'b0);
    run_layer(0, 1'b0, 1'b1, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    chk("poke_busy", busy, 0);
    chk("poke_dones", dones_seen, dones_exp);
    chk("poke_no_output", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
